// File: rtl/st_bus_master.sv
// st_bus_master
//   Initiating end of the 68000-style AS/DS/DTACK handshake on the ST
//   motherboard bus. It takes one word/byte request from on-card logic,
//   runs a single complete bus cycle, and then reports read data or an error.
//
//   Request handshake (REQ / BUSY / DONE):
//     REQ is sampled only while the FSM is idle. It is taken when BUS_OWN is
//     high and the recovery time has expired. A REQ seen while BUS_OWN is low
//     is not dropped: it is accepted on the first idle edge after the grant.
//     BUSY rises on the accept edge and falls on the same edge that raises
//     DONE. DONE is a one-cycle pulse, and ERR is meaningful only while DONE
//     is high. RDATA is updated only by an error-free read and holds its value
//     until the next one completes.
//
//   Ports
//     CLKOSC, RST          clock, asynchronous active-low reset
//     BUS_OWN              bus granted to this card
//     REQ, REQ_*           request strobe and its attributes (latched on accept)
//     BUSY, DONE, ERR      request status
//     RDATA                read data
//     BUS_OE               enable for AS/UDS/LDS/RW/A/FC drivers (gated at top level)
//     AS, UDS, LDS         active-low strobes
//     RW, A, FC            cycle attributes driven to the bus
//     D_OUT, D_OE          write data and its driver enable
//     D_IN                 bus data
//     DTACK, BERR          asynchronous active-low slave responses
//     dbg_state            current FSM state (debug)
module st_bus_master #(
  parameter int TIMEOUT  = 255,  // CLKOSC cycles from AS low to forced error (1..255)
  parameter int DS_DELAY = 1,    // write: cycles from AS low to DS low
  parameter int RECOVER  = 2     // minimum cycles AS stays high between cycles
) (
  input  logic        CLKOSC,
  input  logic        RST,
  input  logic        BUS_OWN,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_A,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic [2:0]  REQ_FC,
  input  logic [15:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BUS_OE,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [22:0] A,
  output logic [2:0]  FC,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  input  logic        DTACK,
  input  logic        BERR,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_STROBE  = 3'd2,
    S_WAIT    = 3'd3,
    S_LATCH   = 3'd4,
    S_TERM    = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] DS_CNT  = 8'(DS_DELAY);
  localparam logic [7:0] REC_LD  = 8'(RECOVER);
  localparam bit         DS_NOW  = (DS_DELAY == 0);

  state_t      state;
  logic        dtack_m, dtack_s;
  logic        berr_m, berr_s;
  logic [7:0]  to_cnt;
  logic [7:0]  rec_cnt;
  logic        err_r;
  logic        rw_r;
  logic [22:0] a_r;
  logic        uds_r, lds_r;
  logic [2:0]  fc_r;
  logic [15:0] wd_r;

  assign dbg_state = state;

  // Each state's actions take effect on the edge that leaves it, so the
  // bus outputs lag the state by one cycle. The accept edge therefore
  // drives AS low two edges later, and DONE follows TERM by one edge.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      dtack_m <= 1'b1;
      dtack_s <= 1'b1;
      berr_m  <= 1'b1;
      berr_s  <= 1'b1;
      to_cnt  <= 8'd0;
      rec_cnt <= 8'd0;
      err_r   <= 1'b0;
      rw_r    <= 1'b1;
      a_r     <= 23'd0;
      uds_r   <= 1'b1;
      lds_r   <= 1'b1;
      fc_r    <= 3'd0;
      wd_r    <= 16'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= 16'd0;
      BUS_OE  <= 1'b0;
      AS      <= 1'b1;
      UDS     <= 1'b1;
      LDS     <= 1'b1;
      RW      <= 1'b1;
      A       <= 23'd0;
      FC      <= 3'd0;
      D_OUT   <= 16'd0;
      D_OE    <= 1'b0;
    end else begin
      dtack_m <= DTACK;
      dtack_s <= dtack_m;
      berr_m  <= BERR;
      berr_s  <= berr_m;
      DONE    <= 1'b0;
      ERR     <= 1'b0;

      if (rec_cnt != 8'd0)
        rec_cnt <= rec_cnt - 8'd1;

      // Saturating count of cycles since AS went low.
      if ((state == S_STROBE || state == S_WAIT) && to_cnt != 8'hFF)
        to_cnt <= to_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (REQ && BUS_OWN && rec_cnt == 8'd0) begin
            rw_r  <= REQ_RW;
            a_r   <= REQ_A;
            uds_r <= REQ_UDS;
            lds_r <= REQ_LDS;
            fc_r  <= REQ_FC;
            wd_r  <= REQ_WDATA;
            err_r <= 1'b0;
            BUSY  <= 1'b1;
            state <= S_ADDR;
          end
        end

        S_ADDR: begin
          BUS_OE <= 1'b1;
          A      <= a_r;
          FC     <= fc_r;
          RW     <= rw_r;
          D_OUT  <= wd_r;
          D_OE   <= !rw_r;
          to_cnt <= 8'd0;
          state  <= S_STROBE;
        end

        S_STROBE: begin
          AS <= 1'b0;
          if (rw_r || DS_NOW) begin
            UDS <= uds_r;
            LDS <= lds_r;
          end
          state <= S_WAIT;
        end

        S_WAIT: begin
          // Write strobes follow AS by DS_DELAY cycles so D_OUT is settled first.
          if (!rw_r && to_cnt == DS_CNT) begin
            UDS <= uds_r;
            LDS <= lds_r;
          end
          // BERR has priority over DTACK; a response beats the timeout.
          if (!berr_s) begin
            err_r <= 1'b1;
            state <= S_TERM;
          end else if (!dtack_s) begin
            state <= S_LATCH;
          end else if (to_cnt >= TO_MAX) begin
            err_r <= 1'b1;
            state <= S_TERM;
          end
        end

        S_LATCH: begin
          // The two synchroniser stages give D_IN ample setup after DTACK.
          if (rw_r)
            RDATA <= D_IN;
          state <= S_TERM;
        end

        S_TERM: begin
          AS      <= 1'b1;
          UDS     <= 1'b1;
          LDS     <= 1'b1;
          D_OE    <= 1'b0;
          DONE    <= 1'b1;
          ERR     <= err_r;
          BUSY    <= 1'b0;
          rec_cnt <= REC_LD;
          state   <= S_RELEASE;
        end

        S_RELEASE: begin
          // No timeout here: a slave that never releases keeps the bus held.
          if (dtack_s && berr_s) begin
            BUS_OE <= 1'b0;
            RW     <= 1'b1;
            state  <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st_bus_master.sv
// Testbench for st_bus_master: table of directed bus cycles, hand-written
// reset-in-WAIT sequence, then randomized cycles against a timing model.
module tb_st_bus_master;

  localparam int TIMEOUT  = 255;
  localparam int DS_DELAY = 1;
  localparam int RECOVER  = 2;

  logic        CLKOSC = 1'b0;
  logic        RST;
  logic        BUS_OWN, REQ, REQ_RW, REQ_UDS, REQ_LDS;
  logic [22:0] REQ_A;
  logic [2:0]  REQ_FC;
  logic [15:0] REQ_WDATA, D_IN;
  logic        DTACK, BERR;
  logic        BUSY, DONE, ERR, BUS_OE, AS, UDS, LDS, RW, D_OE;
  logic [15:0] RDATA, D_OUT;
  logic [22:0] A;
  logic [2:0]  FC;
  logic [2:0]  dbg_state;

  st_bus_master #(.TIMEOUT(TIMEOUT), .DS_DELAY(DS_DELAY), .RECOVER(RECOVER)) dut (
    .CLKOSC(CLKOSC), .RST(RST), .BUS_OWN(BUS_OWN), .REQ(REQ), .REQ_RW(REQ_RW),
    .REQ_A(REQ_A), .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_FC(REQ_FC),
    .REQ_WDATA(REQ_WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .BUS_OE(BUS_OE), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .A(A), .FC(FC),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .DTACK(DTACK), .BERR(BERR),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 CLKOSC = ~CLKOSC;

  int cyc_g = 0;
  always @(posedge CLKOSC) cyc_g <= cyc_g + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_rdata;
  int          earliest_acc;

  typedef struct {
    logic        rw;
    logic [22:0] a;
    logic        uds, lds;
    logic [2:0]  fc;
    logic [15:0] wd, din;
    int          k;          // response delay after AS low; -1 none, -2 already low
    logic        berr;       // BERR asserted together with DTACK
    int          hold;       // cycles slave keeps response after AS rises
    int          own_delay;  // cycles BUS_OWN stays low after REQ
    logic        own_drop;   // BUS_OWN dropped as AS falls
    logic        exp_err;
    int          exp_delta;  // cycles from AS low to DONE
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Cycle-level model. A response driven k cycles after AS low reaches the
  // FSM after two synchroniser flops, is seen on the following edge, then
  // costs one LATCH cycle (DTACK only) and one TERM cycle before DONE.
  // A response already present before AS is seen on the first WAIT edge.
  // With no response the cycle is killed so that DONE lands TIMEOUT+1
  // cycles after AS low.
  function automatic int model_delta(input int k, input logic berr);
    int keff;
    keff = (k == -2) ? -2 : k;
    if (k == -1 || keff + 3 > TIMEOUT) return TIMEOUT + 1;
    return berr ? keff + 4 : keff + 5;
  endfunction

  function automatic logic model_err(input int k, input logic berr);
    return (k == -1) || (k >= 0 && k + 3 > TIMEOUT) || berr;
  endfunction

  function automatic vec_t mk(input logic rw, input logic [22:0] a, input logic uds,
                              input logic lds, input logic [2:0] fc, input logic [15:0] wd,
                              input logic [15:0] din, input int k, input logic berr,
                              input int hold, input int own_delay, input logic own_drop,
                              input logic exp_err, input int exp_delta);
    vec_t v;
    v.rw = rw; v.a = a; v.uds = uds; v.lds = lds; v.fc = fc; v.wd = wd; v.din = din;
    v.k = k; v.berr = berr; v.hold = hold; v.own_delay = own_delay; v.own_drop = own_drop;
    v.exp_err = exp_err; v.exp_delta = exp_delta;
    return v;
  endfunction

  task automatic hard_reset();
    RST = 1'b0; REQ = 1'b0; DTACK = 1'b1; BERR = 1'b1; BUS_OWN = 1'b1;
    repeat (2) @(posedge CLKOSC);
    #1 RST = 1'b1;
    earliest_acc = 0;
  endtask

  // ---------------- driver + slave + monitor for one bus cycle ----------------
  task automatic run_txn(input vec_t v);
    int req_cyc, grant_cyc, acc, as_c, done_c, drop_c, rel_c, c, exp_acc, exp_drop;
    logic slave_on;
    logic [15:0] exp_rd;
    req_cyc = cyc_g;
    grant_cyc = req_cyc + v.own_delay;
    REQ_RW = v.rw; REQ_A = v.a; REQ_UDS = v.uds; REQ_LDS = v.lds;
    REQ_FC = v.fc; REQ_WDATA = v.wd; D_IN = v.din;
    slave_on = 1'b0;
    if (v.k == -2) begin
      slave_on = 1'b1; DTACK = 1'b0; BERR = !v.berr;
    end
    if (v.own_delay > 0) BUS_OWN = 1'b0;
    REQ = 1'b1;
    acc = -1; as_c = -1; done_c = -1; drop_c = -1; rel_c = -1;
    for (int n = 0; n < 600 && drop_c < 0; n++) begin
      @(posedge CLKOSC); #1;
      c = cyc_g;
      // ---- observe ----
      if (acc < 0 && BUSY) begin
        acc = c;
        REQ = 1'b0;
        exp_acc = imax(imax(earliest_acc, req_cyc + 1), grant_cyc + 1);
        check("accept_cycle", 64'(acc), 64'(exp_acc));
      end
      if (acc >= 0 && c == acc + 1)
        check("addr_phase", {BUS_OE, AS, UDS, LDS, RW, D_OE, FC, A},
              {1'b1, 1'b1, 1'b1, 1'b1, v.rw, !v.rw, v.fc, v.a});
      if (acc >= 0 && c == acc + 1 && !v.rw)
        check("write_data", 64'(D_OUT), 64'(v.wd));
      if (acc >= 0 && as_c < 0 && !AS) begin
        as_c = c;
        check("as_latency", 64'(as_c - acc), 64'd2);
        check("ds_at_as", {UDS, LDS}, v.rw ? {v.uds, v.lds} : 2'b11);
      end
      if (as_c >= 0 && c == as_c + DS_DELAY && !v.rw)
        check("write_ds", {UDS, LDS, D_OE}, {v.uds, v.lds, 1'b1});
      if (as_c >= 0 && done_c < 0 && DONE) begin
        done_c = c;
        exp_rd = (v.rw && !v.exp_err) ? v.din : exp_rdata;
        check("done_delta", 64'(done_c - as_c), 64'(v.exp_delta));
        check("err", 64'(ERR), 64'(v.exp_err));
        check("end_outputs", {BUSY, AS, UDS, LDS, D_OE, BUS_OE}, 6'b011101);
        check("rdata", 64'(RDATA), 64'(exp_rd));
        exp_rdata = exp_rd;
      end
      if (done_c >= 0 && c == done_c + 1)
        check("done_pulse", 64'(DONE), 64'd0);
      if (done_c >= 0 && drop_c < 0 && !BUS_OE) begin
        drop_c = c;
        // Release is seen through the synchroniser; without a response the
        // bus is freed on the first RELEASE edge.
        exp_drop = (rel_c >= 0) ? rel_c + 3 : done_c + 1;
        check("bus_oe_drop", 64'(drop_c), 64'(exp_drop));
      end
      // ---- drive ----
      if (v.own_delay > 0 && c == grant_cyc) BUS_OWN = 1'b1;
      if (v.own_drop && as_c >= 0 && c == as_c) BUS_OWN = 1'b0;
      if (!slave_on && as_c >= 0 && done_c < 0 && v.k >= 0 && c - as_c >= v.k) begin
        slave_on = 1'b1; DTACK = 1'b0; BERR = !v.berr;
      end
      if (slave_on && done_c >= 0 && rel_c < 0 && c >= done_c + v.hold) begin
        rel_c = c; DTACK = 1'b1; BERR = 1'b1;
      end
    end
    if (drop_c < 0) begin
      checks++; errors++;
      $display("FAIL txn_complete: acc=%0d as=%0d done=%0d, bus never released", acc, as_c, done_c);
      hard_reset();
      exp_rdata = 16'h0;
    end else begin
      earliest_acc = imax(drop_c + 1, done_c + RECOVER + 1);
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[11];
  vec_t rv;

  initial begin
    int as_seen, done_seen;
    RST = 1'b0; BUS_OWN = 1'b1; REQ = 1'b0; REQ_RW = 1'b1; REQ_A = '0;
    REQ_UDS = 1'b1; REQ_LDS = 1'b1; REQ_FC = '0; REQ_WDATA = '0; D_IN = '0;
    DTACK = 1'b1; BERR = 1'b1;
    exp_rdata = 16'h0;
    earliest_acc = 0;

    repeat (3) @(posedge CLKOSC);
    #1;
    check("reset_ctrl", {AS, UDS, LDS, RW, BUS_OE, D_OE, BUSY, DONE, ERR}, 9'b1111_00000);
    check("reset_rdata", 64'(RDATA), 64'd0);
    check("reset_a_fc", {A, FC}, 26'd0);
    RST = 1'b1;

    // rw, a, uds, lds, fc, wd, din, k, berr, hold, own_delay, own_drop, exp_err, exp_delta
    tbl[0]  = mk(1, 23'h7E0000, 0, 0, 3'd6, 16'h0000, 16'h602E,  2, 0, 0,  0, 0, 0,   7);
    tbl[1]  = mk(0, 23'h200000, 0, 0, 3'd5, 16'h1234, 16'h0000,  1, 0, 3,  0, 0, 0,   6);
    tbl[2]  = mk(1, 23'h123456, 0, 0, 3'd2, 16'h0000, 16'hAAAA, -1, 0, 0,  0, 0, 1, 256);
    tbl[3]  = mk(1, 23'h000100, 0, 0, 3'd6, 16'h0000, 16'h5A5A,  0, 0, 0,  0, 0, 0,   5);
    tbl[4]  = mk(1, 23'h7FFFFF, 0, 0, 3'd1, 16'h0000, 16'hBEEF,  3, 1, 1,  0, 0, 1,   7);
    tbl[5]  = mk(1, 23'h000002, 0, 1, 3'd5, 16'h0000, 16'hC0DE, -2, 0, 2,  0, 0, 0,   3);
    tbl[6]  = mk(0, 23'h0ABCDE, 1, 1, 3'd1, 16'hFFFF, 16'h0000,  0, 0, 0,  0, 0, 0,   5);
    tbl[7]  = mk(1, 23'h3C0000, 0, 1, 3'd6, 16'h0000, 16'h1357,  4, 0, 1,  0, 1, 0,   9);
    tbl[8]  = mk(1, 23'h3C0001, 1, 0, 3'd6, 16'h0000, 16'h2468,  1, 0, 0, 10, 0, 0,   6);
    tbl[9]  = mk(0, 23'h100000, 0, 0, 3'd5, 16'h8001, 16'h0000, -2, 1, 0,  0, 0, 1,   2);
    tbl[10] = mk(0, 23'h155555, 1, 0, 3'd1, 16'h00FF, 16'h0000,  5, 0, 0,  0, 0, 0,  10);

    @(posedge CLKOSC); #1;
    for (int i = 0; i < 11; i++) run_txn(tbl[i]);

    // Reset while the master waits for a response that never comes.
    REQ_RW = 1'b1; REQ_A = 23'h0F0F0F; REQ_UDS = 1'b0; REQ_LDS = 1'b0; REQ_FC = 3'd6;
    REQ = 1'b1;
    as_seen = 0;
    for (int n = 0; n < 20 && as_seen == 0; n++) begin
      @(posedge CLKOSC); #1;
      if (BUSY) REQ = 1'b0;
      if (!AS) as_seen = 1;
    end
    check("rst_seq_as_low", 64'(as_seen), 64'd1);
    repeat (5) @(posedge CLKOSC);
    #2 RST = 1'b0;
    #1;
    check("rst_async_outputs", {AS, UDS, LDS, BUS_OE, BUSY, DONE, D_OE}, 7'b1110000);
    REQ = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(posedge CLKOSC); #1;
      if (DONE) done_seen++;
    end
    RST = 1'b1;
    earliest_acc = 0;
    repeat (20) begin
      @(posedge CLKOSC); #1;
      if (DONE) done_seen++;
    end
    check("rst_no_done", 64'(done_seen), 64'd0);
    run_txn(mk(1, 23'h000400, 0, 0, 3'd5, 16'h0, 16'h4E71, 2, 0, 0, 0, 0, 0, 7));

    // Randomized cycles checked against the timing model.
    for (int i = 0; i < 40; i++) begin
      int sel;
      rv.rw = 1'($urandom_range(0, 1));
      rv.a = 23'($urandom);
      rv.uds = 1'($urandom_range(0, 1));
      rv.lds = 1'($urandom_range(0, 1));
      rv.fc = 3'($urandom_range(0, 7));
      rv.wd = 16'($urandom);
      rv.din = 16'($urandom);
      sel = $urandom_range(0, 9);
      rv.k = (sel == 0) ? -1 : (sel == 1) ? -2 : int'($urandom_range(0, 9));
      rv.berr = ($urandom_range(0, 3) == 0);
      rv.hold = $urandom_range(0, 3);
      rv.own_delay = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      rv.own_drop = 1'b0;
      rv.exp_err = model_err(rv.k, rv.berr);
      rv.exp_delta = model_delta(rv.k, rv.berr);
      run_txn(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
